// File: rtl/opb_status_pkg.sv
// Shared definitions for the OPB status bank: register-map offsets and decode types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package opb_status_pkg;

    // Which register class an in-window word offset selects
    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_STATUS = 2'd1,
        REG_EVCNT  = 2'd2,
        REG_CTRL   = 2'd3
    } reg_sel_t;

    localparam int STATUS_OFS      = 0;
    localparam int CTRL_FREEZE_BIT = 0;

    // Word offset of the first event counter
    function automatic int EVCNT_OFS(input int n_chan);
        return n_chan;
    endfunction

    // Word offset of the control register
    function automatic int CTRL_OFS(input int n_chan);
        return 2 * n_chan;
    endfunction

    // Ceiling log2 for sizing index fields
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_status_chan.sv
// One status channel: live/sticky capture register, rising-edge detect, saturating event counter.
// Latency: data at cycle t is visible in status/evcnt at t+1.
// Backpressure: none; consumes data every cycle, clear/w1c strobes are single-cycle.
module opb_status_chan #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter bit STICKY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              freeze,
    input  logic [DATA_W-1:0] w1c,
    input  logic              cnt_clr,
    output logic [DATA_W-1:0] status,
    output logic [CNT_W-1:0]  evcnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic prev_any;
    logic ev_cnt;

    // An edge only counts while not frozen; frozen edges are deliberately lost
    assign ev_cnt = (|data) & ~prev_any & ~freeze;

    // Capture register: sticky accumulates even while frozen so no event is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= '0;
        end else if (STICKY) begin
            status <= (status & ~w1c) | data;
        end else if (!freeze) begin
            status <= data;
        end
    end

    // Edge history tracks the input every cycle, independent of freeze
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_any <= 1'b0;
        end else begin
            prev_any <= |data;
        end
    end

    // Saturating counter; a clear coinciding with a counted edge leaves 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evcnt <= '0;
        end else if (cnt_clr) begin
            evcnt <= CNT_W'(ev_cnt);
        end else if (ev_cnt && (evcnt != CNT_MAX)) begin
            evcnt <= evcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/opb_status_bank.sv
// OPB slave exposing N channel status words, event counters and a freeze control bit.
// Latency: ack one cycle after hit; read data sampled at hit; writes land on the ack-cycle edge.
// Backpressure: none beyond the single-cycle ack; a held select is acked once until released.
module opb_status_bank
    import opb_status_pkg::*;
#(
    parameter logic [31:0]        C_BASEADDR   = 32'h01080700,
    parameter logic [31:0]        C_HIGHADDR   = 32'h010807FF,
    parameter int                 C_OPB_AWIDTH = 32,
    parameter int                 C_OPB_DWIDTH = 32,
    parameter string              C_FAMILY     = "virtex5",
    parameter int                 N_CHAN       = 4,
    parameter int                 DATA_W       = 32,
    parameter logic [N_CHAN-1:0]  STICKY_MASK  = '0,
    parameter int                 CNT_W        = 16
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [0:31]              OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:31]              OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:31]              Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    input  logic [N_CHAN*DATA_W-1:0] user_data_in
);

    localparam int IDX_W = (N_CHAN > 1) ? clog2(N_CHAN) : 1;

    logic [31:0]       abus;
    logic [31:0]       wdat;
    logic [31:0]       byte_ofs;
    logic [29:0]       word_ofs;
    logic [31:0]       be_mask;
    logic [31:0]       rd_dat;
    logic              in_win;
    logic              hit;
    logic              ack_done;
    logic              wr_en;
    logic              freeze;
    reg_sel_t          reg_sel;
    logic [IDX_W-1:0]  chan_idx;

    logic [DATA_W-1:0] status  [N_CHAN];
    logic [CNT_W-1:0]  evcnt   [N_CHAN];
    logic [DATA_W-1:0] w1c     [N_CHAN];
    logic [N_CHAN-1:0] cnt_clr;

    logic              unused_bits;

    // OPB bit 0 is the MSB, so a straight vector copy gives natural numbering
    assign abus     = OPB_ABus;
    assign wdat     = OPB_DBus;
    assign in_win   = (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign byte_ofs = abus - C_BASEADDR;
    assign word_ofs = byte_ofs[31:2];

    // Ack_done and the outstanding ack both suppress a second hit for one select
    assign hit   = OPB_select & in_win & ~ack_done & ~Sl_xferAck;
    assign wr_en = Sl_xferAck & OPB_select & ~OPB_RNW;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign unused_bits = ^{OPB_seqAddr, byte_ofs[1:0]};

    // Decode word offset into register class and channel index
    always_comb begin
        reg_sel  = REG_NONE;
        chan_idx = '0;
        if (in_win) begin
            for (int k = 0; k < N_CHAN; k++) begin
                if (word_ofs == 30'(STATUS_OFS + k)) begin
                    reg_sel  = REG_STATUS;
                    chan_idx = IDX_W'(k);
                end
                if (word_ofs == 30'(EVCNT_OFS(N_CHAN) + k)) begin
                    reg_sel  = REG_EVCNT;
                    chan_idx = IDX_W'(k);
                end
            end
            if (word_ofs == 30'(CTRL_OFS(N_CHAN))) begin
                reg_sel = REG_CTRL;
            end
        end
    end

    // Expand byte enables; BE[0] covers the most significant byte
    always_comb begin
        be_mask = '0;
        for (int b = 0; b < 4; b++) begin
            be_mask[31-8*b -: 8] = {8{OPB_BE[b]}};
        end
    end

    // Read mux, zero-extending narrow channel fields
    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (chan_idx == IDX_W'(k)) begin
                if (reg_sel == REG_STATUS) rd_dat = 32'(status[k]);
                if (reg_sel == REG_EVCNT)  rd_dat = 32'(evcnt[k]);
            end
        end
        if (reg_sel == REG_CTRL) rd_dat[CTRL_FREEZE_BIT] = freeze;
    end

    // Per-channel write strobes: W1C mask for status, clear pulse for counters
    always_comb begin
        for (int k = 0; k < N_CHAN; k++) begin
            w1c[k]     = '0;
            cnt_clr[k] = 1'b0;
            if (wr_en && (chan_idx == IDX_W'(k))) begin
                if (reg_sel == REG_STATUS) w1c[k]     = DATA_W'(wdat & be_mask);
                if (reg_sel == REG_EVCNT)  cnt_clr[k] = |OPB_BE;
            end
        end
    end

    // OPB handshake: single-cycle ack, read data only present in the ack cycle
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
            ack_done   <= 1'b0;
        end else begin
            Sl_xferAck <= hit;
            Sl_DBus    <= (hit && OPB_RNW) ? rd_dat : '0;
            if (!OPB_select) begin
                ack_done <= 1'b0;
            end else if (Sl_xferAck) begin
                ack_done <= 1'b1;
            end
        end
    end

    // Freeze control bit lives in the low byte
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            freeze <= 1'b0;
        end else if (wr_en && (reg_sel == REG_CTRL) && OPB_BE[3]) begin
            freeze <= wdat[CTRL_FREEZE_BIT];
        end
    end

    for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
        opb_status_chan #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W),
            .STICKY (STICKY_MASK[k])
        ) u_chan (
            .clk     (OPB_Clk),
            .rst     (OPB_Rst),
            .data    (user_data_in[k*DATA_W +: DATA_W]),
            .freeze  (freeze),
            .w1c     (w1c[k]),
            .cnt_clr (cnt_clr[k]),
            .status  (status[k]),
            .evcnt   (evcnt[k])
        );
    end

endmodule

// File: tb/tb_opb_status_bank.sv
// Testbench for opb_status_bank: directed register-map scenarios plus randomized traffic.
// Latency: drives on falling edge, samples outputs on falling edge after each rising edge.
// Backpressure: bus master holds select through the ack cycle, then idles one cycle.
module tb_opb_status_bank;

    localparam int          N      = 4;
    localparam int          DW     = 32;
    localparam int          CW     = 4;
    localparam logic [3:0]  STICKY = 4'b1010;
    localparam logic [31:0] BASE   = 32'h01080700;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [0:31]   abus;
    logic [0:3]    be;
    logic [0:31]   dbus;
    logic          rnw;
    logic          sel;
    logic          seqaddr;
    logic [0:31]   sl_dbus;
    logic          ack;
    logic          err_ack;
    logic          retry;
    logic          tout_sup;
    logic [N*DW-1:0] user_data;
    logic [31:0]   ud [N];

    int n_checks;
    int n_errors;

    // Reference model state
    logic [31:0] m_st   [N];
    int          m_cnt  [N];
    bit          m_prev [N];
    bit          m_frz;
    bit          wp_en;
    int          wp_ofs;
    logic [0:3]  wp_be;
    logic [31:0] wp_dat;

    opb_status_bank #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (32'h010807FF),
        .N_CHAN      (N),
        .DATA_W      (DW),
        .STICKY_MASK (STICKY),
        .CNT_W       (CW)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seqaddr),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (ack),
        .Sl_errAck    (err_ack),
        .Sl_retry     (retry),
        .Sl_toutSup   (tout_sup),
        .user_data_in (user_data)
    );

    always_comb begin
        user_data = '0;
        for (int k = 0; k < N; k++) user_data[k*DW +: DW] = ud[k];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [0:3] b);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) m |= 32'hFF << (24 - 8*i);
        return m;
    endfunction

    function automatic logic [31:0] model_read(input int ofs);
        if (ofs < N)            return m_st[ofs];
        else if (ofs < 2*N)     return 32'(m_cnt[ofs-N]);
        else if (ofs == 2*N)    return {31'h0, m_frz};
        else                    return 32'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_st[k] = '0; m_cnt[k] = 0; m_prev[k] = 1'b0;
        end
        m_frz = 1'b0;
        wp_en = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs and any landing write
    task automatic model_step();
        logic [31:0] clr_bits;
        bit clr, ev;
        for (int k = 0; k < N; k++) begin
            clr_bits = (wp_en && wp_ofs == k) ? (wp_dat & byte_mask(wp_be)) : 32'h0;
            clr      = wp_en && (wp_ofs == N + k) && (wp_be != 4'b0000);
            ev       = (ud[k] != 0) && !m_prev[k] && !m_frz;
            if (STICKY[k])   m_st[k] = (m_st[k] & ~clr_bits) | ud[k];
            else if (!m_frz) m_st[k] = ud[k];
            if (clr)                           m_cnt[k] = ev ? 1 : 0;
            else if (ev && m_cnt[k] < CMAX)    m_cnt[k] = m_cnt[k] + 1;
            m_prev[k] = (ud[k] != 0);
        end
        if (wp_en && wp_ofs == 2*N && wp_be[3]) m_frz = wp_dat[0];
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_read(input int ofs, output logic [31:0] d);
        logic [31:0] exp;
        sel  = 1'b1; rnw = 1'b1; be = 4'b1111;
        abus = BASE + 32'(ofs * 4);
        exp  = model_read(ofs);
        step();
        check($sformatf("rd_ack ofs%0d", ofs), 32'(ack), 32'h1);
        check($sformatf("rd_dat ofs%0d", ofs), sl_dbus, exp);
        d = sl_dbus;
        step();
        sel = 1'b0;
        check($sformatf("rd_ack_once ofs%0d", ofs), 32'(ack), 32'h0);
        step();
    endtask

    task automatic bus_write(input int ofs, input logic [0:3] b, input logic [31:0] d, input int edge_ch);
        sel  = 1'b1; rnw = 1'b0; be = b; dbus = d;
        abus = BASE + 32'(ofs * 4);
        step();
        check($sformatf("wr_ack ofs%0d", ofs), 32'(ack), 32'h1);
        if (edge_ch >= 0) ud[edge_ch] = 32'h1;
        wp_en = 1'b1; wp_ofs = ofs; wp_be = b; wp_dat = d;
        step();
        wp_en = 1'b0;
        sel   = 1'b0;
        dbus  = '0;
        check($sformatf("wr_ack_once ofs%0d", ofs), 32'(ack), 32'h0);
        step();
    endtask

    initial begin
        logic [31:0] d;
        int acks;
        n_checks = 0;
        n_errors = 0;
        abus = '0; be = '0; dbus = '0; rnw = 1'b1; sel = 1'b0; seqaddr = 1'b0;
        for (int k = 0; k < N; k++) ud[k] = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and every mapped word
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dbus", sl_dbus, 32'h0);
        check("const_err", {29'h0, err_ack, retry, tout_sup}, 32'h0);
        for (int o = 0; o <= 2*N; o++) begin
            bus_read(o, d);
            check($sformatf("rst_word%0d", o), d, 32'h0);
        end

        // Live capture and freeze
        ud[0] = 32'hDEADBEEF;
        step();
        bus_read(0, d);
        check("live_ch0", d, 32'hDEADBEEF);
        bus_write(2*N, 4'b0001, 32'h1, -1);
        ud[0] = 32'h1;
        step();
        bus_read(0, d);
        check("frozen_ch0", d, 32'hDEADBEEF);
        bus_read(2*N, d);
        check("ctrl_freeze", d, 32'h1);
        bus_write(2*N, 4'b0001, 32'h0, -1);
        ud[0] = 32'h0;
        step();

        // Sticky W1C on channel 1
        ud[1] = 32'h100;
        step();
        ud[1] = 32'h0;
        step();
        bus_read(1, d);
        check("sticky_hold", d, 32'h100);
        bus_write(1, 4'b0011, 32'h100, -1);
        bus_read(1, d);
        check("sticky_w1c", d, 32'h0);
        ud[1] = 32'h100;
        bus_write(1, 4'b0011, 32'h100, -1);
        ud[1] = 32'h0;
        step();
        bus_read(1, d);
        check("sticky_w1c_vs_set", d, 32'h100);

        // Saturating counter and clear with coincident edge
        for (int i = 0; i < 20; i++) begin
            ud[2] = 32'h4; step();
            ud[2] = 32'h0; step();
        end
        bus_read(N+2, d);
        check("evcnt_sat", d, 32'hF);
        bus_write(N+2, 4'b1111, 32'h0, 2);
        bus_read(N+2, d);
        check("evcnt_clr_edge", d, 32'h1);
        ud[2] = 32'h0;
        step();

        // Held select gets exactly one ack
        sel = 1'b1; rnw = 1'b1; be = 4'b1111; abus = BASE;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            acks += int'(ack);
        end
        check("held_select_acks", 32'(acks), 32'h1);
        sel = 1'b0;
        step();
        step();

        // Unmapped in-window word
        bus_write(2*N+1, 4'b1111, 32'hFFFFFFFF, -1);
        bus_read(2*N+1, d);
        check("unmapped_rd", d, 32'h0);
        for (int o = 0; o <= 2*N; o++) bus_read(o, d);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    for (int k = 0; k < N; k++) begin
                        case ($urandom_range(0, 3))
                            0: ud[k] = 32'h0;
                            1: ud[k] = $urandom;
                            2: ud[k] = 32'h1 << $urandom_range(0, 31);
                            default: ud[k] = ud[k];
                        endcase
                    end
                    step();
                end
                5, 6, 7: bus_read($urandom_range(0, 2*N+1), d);
                8: bus_write($urandom_range(0, 2*N+1), 4'($urandom), $urandom, -1);
                default: step();
            endcase
        end
        for (int k = 0; k < N; k++) ud[k] = '0;
        step();

        // Reset landing in a write's ack cycle
        bus_write(2*N, 4'b0001, 32'h0, -1);
        sel = 1'b1; rnw = 1'b0; be = 4'b0001; dbus = 32'h1;
        abus = BASE + 32'(2*N*4);
        step();
        check("rst_mid_ack_pre", 32'(ack), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_ack", 32'(ack), 32'h0);
        check("rst_mid_dbus", sl_dbus, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; dbus = '0;
        rst = 1'b0;
        step();
        bus_read(2*N, d);
        check("rst_mid_ctrl", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
